// File: rtl/jtdd_pcm_interp.sv
// Linear-interpolating upsampler: ramps from the present output level to each new
// ADPCM sample over 2^STEPS_LOG2 output ticks, then holds; 16-bit saturated output.
module jtdd_pcm_interp #(
    parameter int unsigned W_IN       = 13,
    parameter int unsigned STEPS_LOG2 = 3,
    parameter int unsigned SHIFT      = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic            sample_in,
    input  logic [W_IN-1:0] din,
    output logic [15:0]     dout,
    output logic            sample_out
);

    localparam int unsigned KW = STEPS_LOG2 + 1;
    // delta (W_IN+1 signed) times k (KW bits, zero-extended to signed)
    localparam int unsigned PW = W_IN + KW + 2;
    localparam int unsigned SW = (W_IN + SHIFT + 1 > 17) ? W_IN + SHIFT + 1 : 17;

    localparam logic [KW-1:0]        N     = KW'(1 << STEPS_LOG2);
    localparam logic signed [SW-1:0] S_MAX = SW'(32767);
    localparam logic signed [SW-1:0] S_MIN = SW'(-32768);

    logic signed [W_IN-1:0] a;
    logic signed [W_IN-1:0] b;
    logic [KW-1:0]          k;

    logic signed [W_IN:0]   delta;
    logic signed [PW-1:0]   prod;
    logic signed [W_IN-1:0] interp;
    logic signed [SW-1:0]   shifted;
    logic [15:0]            dout_nxt;

    // Interpolation and saturation; interp always lies between a and b.
    always_comb begin
        delta    = {b[W_IN-1], b} - {a[W_IN-1], a};
        prod     = PW'(delta) * $signed(PW'({1'b0, k}));
        interp   = W_IN'(PW'(a) + (prod >>> STEPS_LOG2));
        shifted  = SW'(interp) <<< SHIFT;
        dout_nxt = 16'(shifted);
        if (shifted > S_MAX) begin
            dout_nxt = 16'h7FFF;
        end else if (shifted < S_MIN) begin
            dout_nxt = 16'h8000;
        end
    end

    // A new sample restarts the ramp from the present level and wins over the k step.
    always_ff @(posedge clk) begin
        if (rst) begin
            a          <= '0;
            b          <= '0;
            k          <= N;
            dout       <= '0;
            sample_out <= 1'b0;
        end else begin
            sample_out <= cen;
            if (cen) begin
                dout <= dout_nxt;
            end
            if (sample_in) begin
                a <= interp;
                b <= $signed(din);
                k <= '0;
            end else if (cen && k != N) begin
                k <= k + KW'(1);
            end
        end
    end

endmodule

// File: tb/tb_jtdd_pcm_interp.sv
// Directed table-driven bench for jtdd_pcm_interp; a second instance with SHIFT=4
// shares the stimulus to exercise output saturation.
module tb_jtdd_pcm_interp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic        sample_in = 1'b0;
    logic [12:0] din = '0;
    logic [15:0] dout, dout4;
    logic        sample_out, sample_out4;

    always #5 clk = ~clk;

    jtdd_pcm_interp dut (
        .clk(clk), .rst(rst), .cen(cen), .sample_in(sample_in),
        .din(din), .dout(dout), .sample_out(sample_out)
    );

    jtdd_pcm_interp #(.W_IN(13), .STEPS_LOG2(3), .SHIFT(4)) dut4 (
        .clk(clk), .rst(rst), .cen(cen), .sample_in(sample_in),
        .din(din), .dout(dout4), .sample_out(sample_out4)
    );

    typedef struct {
        logic rst;
        logic cen;
        logic si;
        int   din;
        int   ei;   // interpolated level expected on dout after this cycle
        logic eso;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_miss = 0;

    function automatic void vec(logic r, logic c, logic s, int d, int ei);
        vec_t v;
        v.rst = r; v.cen = c; v.si = s; v.din = d; v.ei = ei;
        v.eso = c & ~r;
        vecs.push_back(v);
    endfunction

    function automatic logic [15:0] sat_exp(int v, int sh);
        int s;
        s = v * (1 << sh);
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return 16'(s);
    endfunction

    initial begin
        int ramp_b[10];
        int retgt[9];
        int pos[9];
        logic [15:0] e3, e4;

        ramp_b = '{0, 100, 200, 300, 400, 500, 600, 700, 800, 800};
        retgt  = '{500, 437, 375, 312, 250, 187, 125, 62, 0};
        pos    = '{0, 511, 1023, 1535, 2047, 2559, 3071, 3583, 4095};

        // reset then idle: pulses one cycle wide, one cycle after cen
        vec(1, 0, 0, 0, 0);
        vec(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            vec(0, 1, 0, 0, 0);
            vec(0, 0, 0, 0, 0);
        end
        // rising ramp 0 -> 800 with adjacent cen pulses
        vec(0, 0, 1, 800, 0);
        for (int i = 0; i < 10; i++) vec(0, 1, 0, 0, ramp_b[i]);
        // negative floor rounding
        vec(1, 0, 0, 0, 0);
        vec(0, 0, 1, -3, 0);
        vec(0, 1, 0, 0, 0);
        vec(0, 1, 0, 0, -1);
        vec(0, 1, 0, 0, -1);
        // mid-ramp retarget to 0 at k=5
        vec(1, 0, 0, 0, 0);
        vec(0, 0, 1, 800, 0);
        for (int i = 0; i < 5; i++) vec(0, 1, 0, 0, 100 * i);
        vec(0, 0, 1, 0, 400);
        for (int i = 0; i < 9; i++) vec(0, 1, 0, 0, retgt[i]);
        // simultaneous sample_in+cen, then positive saturation
        vec(1, 0, 0, 0, 0);
        vec(0, 1, 1, 4095, 0);
        for (int i = 0; i < 9; i++) vec(0, 1, 0, 0, pos[i]);
        // same for negative full scale
        vec(1, 0, 0, 0, 0);
        vec(0, 1, 1, -4096, 0);
        for (int i = 0; i < 9; i++) vec(0, 1, 0, 0, -512 * i);
        // reset mid-ramp at k=3
        vec(1, 0, 0, 0, 0);
        vec(0, 0, 1, 800, 0);
        for (int i = 0; i < 3; i++) vec(0, 1, 0, 0, 100 * i);
        vec(1, 0, 0, 0, 0);
        vec(1, 1, 0, 0, 0);
        vec(0, 1, 0, 0, 0);
        vec(0, 1, 0, 0, 0);
        // back-to-back sample_in without cen keeps a fixed
        vec(1, 0, 0, 0, 0);
        vec(0, 0, 1, 800, 0);
        vec(0, 0, 1, 400, 0);
        vec(0, 1, 0, 0, 0);
        vec(0, 1, 0, 0, 50);

        foreach (vecs[i]) begin
            rst       = vecs[i].rst;
            cen       = vecs[i].cen;
            sample_in = vecs[i].si;
            din       = 13'(vecs[i].din);
            @(posedge clk);
            #1;
            n_vec++;
            e3 = sat_exp(vecs[i].ei, 3);
            e4 = sat_exp(vecs[i].ei, 4);
            if (dout !== e3) begin
                n_miss++;
                $display("FAIL vec %0d dout: got %0d, want %0d", i, $signed(dout), $signed(e3));
            end
            if (dout4 !== e4) begin
                n_miss++;
                $display("FAIL vec %0d dout_shift4: got %0d, want %0d", i, $signed(dout4), $signed(e4));
            end
            if (sample_out !== vecs[i].eso || sample_out4 !== vecs[i].eso) begin
                n_miss++;
                $display("FAIL vec %0d sample_out: got %b/%b, want %b", i, sample_out, sample_out4, vecs[i].eso);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
